// File: rtl/dpe_pkg.sv
// Shared DPE types: stream addresses, beat bundle, demux egress and state codes.
// DPE_DEMUX_STATS_EN enables per-egress packet counters in dpe_demultiplexer.
package dpe_pkg;

   localparam int DPE_DATA_W  = 64;
   localparam int DPE_KEEP_W  = DPE_DATA_W / 8;
   localparam int DPE_ADDR_W  = 3;
   localparam int DPE_STAGE_W = 4;
   localparam int DPE_NUM_EG  = 5;

   localparam logic [DPE_ADDR_W-1:0] DPE_ADDR_CPU   = 3'd0;
   localparam logic [DPE_ADDR_W-1:0] DPE_ADDR_ETH_1 = 3'd1;
   localparam logic [DPE_ADDR_W-1:0] DPE_ADDR_ETH_2 = 3'd2;
   localparam logic [DPE_ADDR_W-1:0] DPE_ADDR_ETH_3 = 3'd3;
   localparam logic [DPE_ADDR_W-1:0] DPE_ADDR_ETH_4 = 3'd4;

   typedef enum logic [2:0] {
      EG_CPU,
      EG_ETH_1,
      EG_ETH_2,
      EG_ETH_3,
      EG_ETH_4,
      EG_DROP
   } dpe_egress_e;

   typedef enum logic [1:0] {
      SOP,
      MOP,
      DROP
   } demux_state_t;

   typedef struct packed {
      logic [DPE_DATA_W-1:0]  tdata;
      logic [DPE_KEEP_W-1:0]  tkeep;
      logic                   tlast;
      logic                   tuser_bypass_all;
      logic [DPE_STAGE_W-1:0] tuser_bypass_stage;
      logic [DPE_ADDR_W-1:0]  tuser_src;
      logic [DPE_ADDR_W-1:0]  tuser_dst;
   } dpe_beat_t;

   function automatic dpe_egress_e dpe_dst_decode(
      input logic [DPE_ADDR_W-1:0] dst
   );
      dpe_egress_e eg;
      unique case (1'b1)
         dst == DPE_ADDR_CPU:   eg = EG_CPU;
         dst == DPE_ADDR_ETH_1: eg = EG_ETH_1;
         dst == DPE_ADDR_ETH_2: eg = EG_ETH_2;
         dst == DPE_ADDR_ETH_3: eg = EG_ETH_3;
         dst == DPE_ADDR_ETH_4: eg = EG_ETH_4;
         default:               eg = EG_DROP;
      endcase
      return eg;
   endfunction

endpackage

// File: rtl/dpe_if.sv
// DPE AXI-stream style link with tuser sideband.
// Used by dpe_demultiplexer (DPE_DEMUX_STATS_EN adds no signals here).
interface dpe_if;
   import dpe_pkg::*;

   logic                   tvalid;
   logic                   tready;
   logic [DPE_DATA_W-1:0]  tdata;
   logic [DPE_KEEP_W-1:0]  tkeep;
   logic                   tlast;
   logic                   tuser_bypass_all;
   logic [DPE_STAGE_W-1:0] tuser_bypass_stage;
   logic [DPE_ADDR_W-1:0]  tuser_src;
   logic [DPE_ADDR_W-1:0]  tuser_dst;

   modport s_axis (
      input  tvalid, tdata, tkeep, tlast,
      input  tuser_bypass_all, tuser_bypass_stage,
      input  tuser_src, tuser_dst,
      output tready
   );

   modport m_axis (
      output tvalid, tdata, tkeep, tlast,
      output tuser_bypass_all, tuser_bypass_stage,
      output tuser_src, tuser_dst,
      input  tready
   );

endinterface

// File: rtl/dpe_if_skid_buffer.sv
// Two-entry skid buffer onto a dpe_if master: registered outputs, 1 beat/cycle.
// Shared by dpe_demultiplexer egresses (DPE_DEMUX_STATS_EN independent).
module dpe_if_skid_buffer
   import dpe_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      s_valid,
   output logic      s_ready,
   input  dpe_beat_t s_beat,
   dpe_if.m_axis     m
);

   logic      m_valid;
   logic      sk_valid;
   dpe_beat_t m_beat;
   dpe_beat_t sk_beat;

   // The skid slot absorbs the one beat in flight when the sink stalls.
   assign s_ready = ~sk_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid  <= 1'b0;
         sk_valid <= 1'b0;
         m_beat   <= '0;
         sk_beat  <= '0;
      end else if (s_valid && s_ready) begin
         if (!m_valid || m.tready) begin
            m_valid <= 1'b1;
            m_beat  <= s_beat;
         end else begin
            sk_valid <= 1'b1;
            sk_beat  <= s_beat;
         end
      end else if (m.tready) begin
         m_valid  <= sk_valid;
         sk_valid <= 1'b0;
         if (sk_valid) m_beat <= sk_beat;
      end
   end

   assign m.tvalid             = m_valid;
   assign m.tdata              = m_beat.tdata;
   assign m.tkeep              = m_beat.tkeep;
   assign m.tlast              = m_beat.tlast;
   assign m.tuser_bypass_all   = m_beat.tuser_bypass_all;
   assign m.tuser_bypass_stage = m_beat.tuser_bypass_stage;
   assign m.tuser_src          = m_beat.tuser_src;
   assign m.tuser_dst          = m_beat.tuser_dst;

endmodule

// File: rtl/dpe_demultiplexer.sv
// Steers whole DPE packets to CPU/ETH_1..4 by tuser_dst; drops unknown codes.
// Define DPE_DEMUX_STATS_EN for per-egress packet counters (pkt_cnt).
module dpe_demultiplexer
   import dpe_pkg::*;
#(
   parameter int DROP_CNT_W = 16
`ifdef DPE_DEMUX_STATS_EN
  ,parameter int PKT_CNT_W  = 32
`endif
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pause,
   output logic                  is_idle,
   output logic [DROP_CNT_W-1:0] drop_cnt,
   dpe_if.s_axis                 from_dpe,
   dpe_if.m_axis                 to_cpu,
   dpe_if.m_axis                 to_eth_1,
   dpe_if.m_axis                 to_eth_2,
   dpe_if.m_axis                 to_eth_3,
   dpe_if.m_axis                 to_eth_4
`ifdef DPE_DEMUX_STATS_EN
  ,output logic [DPE_NUM_EG-1:0][PKT_CNT_W-1:0] pkt_cnt
`endif
);

   demux_state_t          state, state_nxt;
   dpe_egress_e           sel, sel_q, sel_nxt;
   dpe_beat_t             beat;
   logic [DPE_NUM_EG-1:0] sel_oh, eg_valid, eg_ready, out_valid;
   logic                  go, in_ready, accept, last_acc;

   assign beat = '{
      tdata:              from_dpe.tdata,
      tkeep:              from_dpe.tkeep,
      tlast:              from_dpe.tlast,
      tuser_bypass_all:   from_dpe.tuser_bypass_all,
      tuser_bypass_stage: from_dpe.tuser_bypass_stage,
      tuser_src:          from_dpe.tuser_src,
      tuser_dst:          from_dpe.tuser_dst
   };

   // Pause only gates the start of a packet; open packets always finish.
   always_comb begin
      sel = EG_DROP;
      go  = rst_n;
      unique case (state)
         SOP: begin
            sel = dpe_dst_decode(from_dpe.tuser_dst);
            go  = rst_n & ~pause;
         end
         MOP:     sel = sel_q;
         default: sel = EG_DROP;
      endcase
   end

   always_comb begin
      sel_oh = '0;
      for (int i = 0; i < DPE_NUM_EG; i++)
         sel_oh[i] = (int'(sel) == i);
   end

   assign in_ready = go & ((sel == EG_DROP) | (|(sel_oh & eg_ready)));
   assign eg_valid = sel_oh & {DPE_NUM_EG{go & from_dpe.tvalid}};
   assign accept   = from_dpe.tvalid & in_ready;
   assign last_acc = accept & from_dpe.tlast;

   assign from_dpe.tready = in_ready;

   always_comb begin
      state_nxt = state;
      sel_nxt   = sel_q;
      unique case (state)
         SOP: begin
            if (accept && !from_dpe.tlast) begin
               state_nxt = (sel == EG_DROP) ? DROP : MOP;
               sel_nxt   = sel;
            end
         end
         default: begin
            if (last_acc) state_nxt = SOP;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SOP;
         sel_q <= EG_DROP;
      end else begin
         state <= state_nxt;
         sel_q <= sel_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         drop_cnt <= '0;
      else if (last_acc && sel == EG_DROP && !(&drop_cnt))
         drop_cnt <= drop_cnt + DROP_CNT_W'(1);
   end

`ifdef DPE_DEMUX_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_cnt <= '0;
      end else begin
         for (int i = 0; i < DPE_NUM_EG; i++)
            if (last_acc && sel_oh[i])
               pkt_cnt[i] <= pkt_cnt[i] + PKT_CNT_W'(1);
      end
   end
`endif

   assign out_valid = {to_eth_4.tvalid, to_eth_3.tvalid,
                       to_eth_2.tvalid, to_eth_1.tvalid,
                       to_cpu.tvalid};
   assign is_idle   = pause & (state == SOP) & ~(|out_valid);

   dpe_if_skid_buffer u_eg_cpu (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_valid (eg_valid[0]),
      .s_ready (eg_ready[0]),
      .s_beat  (beat),
      .m       (to_cpu)
   );

   dpe_if_skid_buffer u_eg_eth_1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_valid (eg_valid[1]),
      .s_ready (eg_ready[1]),
      .s_beat  (beat),
      .m       (to_eth_1)
   );

   dpe_if_skid_buffer u_eg_eth_2 (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_valid (eg_valid[2]),
      .s_ready (eg_ready[2]),
      .s_beat  (beat),
      .m       (to_eth_2)
   );

   dpe_if_skid_buffer u_eg_eth_3 (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_valid (eg_valid[3]),
      .s_ready (eg_ready[3]),
      .s_beat  (beat),
      .m       (to_eth_3)
   );

   dpe_if_skid_buffer u_eg_eth_4 (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_valid (eg_valid[4]),
      .s_ready (eg_ready[4]),
      .s_beat  (beat),
      .m       (to_eth_4)
   );

endmodule

// File: doc/dpe_demultiplexer.md
Name: dpe_demultiplexer

Overview:
- Terminal stage of the DPE. Sits after the last processing stage, downstream of dpe_multiplexer and the pipeline it feeds.
- Consumes the single merged DPE stream and steers each whole packet to one of five egress streams (CPU, ETH_1..ETH_4) selected by tuser_dst.
- Drops packets with an unknown destination.
- Supports pause/is_idle flush handshake for the control plane.

Parameters:
- DROP_CNT_W, 16, width of saturating drop counter
- PKT_CNT_W, 32, width of per-port packet counters (only with DPE_DEMUX_STATS_EN)

Ports:
- clk  input  1  DPE clock
- rst_n  input  1  asynchronous active-low reset
- pause  input  1  stop accepting new packets at next packet boundary
- is_idle  output  1  paused, between packets, all egress buffers empty
- drop_cnt  output  DROP_CNT_W  packets discarded for invalid tuser_dst
- from_dpe  dpe_if.s_axis  iface  merged DPE stream
- to_cpu  dpe_if.m_axis  iface  egress to CPU
- to_eth_1  dpe_if.m_axis  iface  egress to ETH port 1
- to_eth_2  dpe_if.m_axis  iface  egress to ETH port 2
- to_eth_3  dpe_if.m_axis  iface  egress to ETH port 3
- to_eth_4  dpe_if.m_axis  iface  egress to ETH port 4
- pkt_cnt  output  5 x PKT_CNT_W  per-egress packet counts, index order CPU, ETH_1..ETH_4 (only with DPE_DEMUX_STATS_EN)

Behaviour:
- Reset (async assert, sync release): state = SOP; all egress tvalid = 0; from_dpe.tready = 0; drop_cnt = 0; is_idle = 0 unless pause = 1.
- FSM states:
  - SOP: first beat of a packet.
    - sel = decode(from_dpe.tuser_dst), combinational: DPE_ADDR_CPU / ETH_1..ETH_4 select one egress; any other code selects DROP.
    - Accepted beat with tlast = 1: stay in SOP (single-beat packet).
    - Accepted beat with tlast = 0: latch sel; go to MOP if sel is valid, else DROP.
  - MOP: sel is the latched value. tuser_dst on later beats is ignored. Accepted tlast -> SOP.
  - DROP: from_dpe.tready = 1; beats discarded. Accepted tlast -> SOP.
  - A dropped packet (single-beat or multi-beat) increments drop_cnt once, on its tlast beat. drop_cnt saturates at all-ones.
- Forwarding:
  - Only the selected egress sees tvalid = from_dpe.tvalid; the other four have tvalid = 0.
  - from_dpe.tready = selected egress buffer's tready.
  - tdata, tkeep, tlast, tuser_bypass_all, tuser_bypass_stage, tuser_src and tuser_dst are passed unchanged.
- Egress buffering: each output goes through its own skid buffer.
  - Latency 1 cycle from input handshake to egress tvalid.
  - Full throughput, 1 beat/cycle.
  - Backpressure on one egress never affects buffered beats on other egresses.
- Pause:
  - Sampled only in SOP. pause = 1 in SOP gives from_dpe.tready = 0 and no new packet starts.
  - A packet in MOP or DROP always completes regardless of pause.
  - is_idle = pause & (state == SOP) & no egress tvalid.
- Simultaneous events:
  - Input tvalid and pause rising in the same SOP cycle: the packet is not accepted.
  - tlast accepted while pause = 1: return to SOP and hold there.
- Reset mid-packet: FSM returns to SOP and egress buffers are cleared. The upstream remainder is treated as a new packet; this is a documented, accepted behaviour.

Optional Feature:
- Macro DPE_DEMUX_STATS_EN.
- Defined: pkt_cnt port exists. Each entry increments once per packet on the accepted tlast beat to that egress, wraps modulo 2^PKT_CNT_W, and resets to 0.
- Undefined: pkt_cnt port and its counters are absent. Routing behaviour is identical.

Decomposition:
- dpe_pkg holds:
  - the DPE_ADDR_* constants (existing)
  - new typedef dpe_egress_e {EG_CPU, EG_ETH_1..EG_ETH_4, EG_DROP}
  - function dpe_dst_decode(tuser_dst) -> dpe_egress_e
  - demux_state_t {SOP, MOP, DROP}
- Egress buffers reuse the existing dpe_if_skid_buffer (five instances).
- No new sub-module is needed.

Test Plan:
- Single-beat packet, tuser_dst = DPE_ADDR_ETH_2, all readys 1 -> to_eth_2 tvalid one cycle later with identical tdata/tkeep/tlast = 1; the other four egresses stay tvalid = 0.
- 8-beat packet to ETH_3 with tuser_dst changed to CPU on beat 4 -> all 8 beats appear on to_eth_3 only; to_cpu sees nothing.
- 5-beat packet with tuser_dst = invalid code, followed by a CPU packet -> from_dpe.tready = 1 for all 5 beats; no egress activity; drop_cnt 0 -> 1; the CPU packet is forwarded immediately after.
- Hold to_eth_1 tready = 0 for 10 cycles during a 4-beat ETH_1 packet -> from_dpe.tready drops once the buffer is full; no beat is lost or duplicated; the packet completes after release.
- Assert pause at beat 2 of a 6-beat CPU packet -> packet completes; then from_dpe.tready = 0; is_idle = 1 once to_cpu drains; deassert pause -> next packet accepted.
- With DPE_DEMUX_STATS_EN defined: send 3 packets to ETH_4 and 2 to CPU -> pkt_cnt[ETH_4] = 3, pkt_cnt[CPU] = 2, others 0; assert rst_n low mid-packet -> all counters and tvalids 0 immediately, without waiting for a clock edge.
